bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Iterative shift-and-add-3 (double-dabble) converter: one unsigned binary value in, packed 4-bit BCD digits out.
- Sits directly upstream of the per-digit seven-segment hex decoders; each 4-bit output nibble drives one decoder.
- Blanked and overflow digits are encoded as 4'hF. The decoder renders any non-decimal code as all segments off, so 4'hF gives a blank digit.
- Start/busy/done handshake; result held stable between conversions.

Parameters:
- BIN_W, 14, width of binary input (14 bits covers 0..9999).
- DIGITS, 4, number of BCD output digits.
- BLANK_LZ, 1, 1 = replace leading zero digits with 4'hF; 0 = show all zeros.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request conversion of bin; sampled only in IDLE.
- bin  input  BIN_W  unsigned value to convert; sampled on the accepting edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  4*DIGITS  packed digits; [3:0] is the least significant digit.
- overflow  output  1  high when the last converted bin exceeded 10^DIGITS-1.

Behaviour:
- Reset (synchronous, active-high; clk and reset per the decided interface):
  - bcd = all nibbles 4'hF (display blank); busy=0, done=0, overflow=0; state IDLE.
  - Reset asserted mid-conversion aborts immediately to these values; no done pulse.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - start=1 at edge N: load shift register = {4*DIGITS zeros, bin}; iteration counter = BIN_W.
  - Latch ovf_pend = (bin > 10^DIGITS-1); the compare uses a constant of adequate width.
  - Go to SHIFT; busy=1 after edge N.
- SHIFT, one iteration per cycle:
  - Every BCD nibble >= 5 gets +3 (4-bit add, no carry out of nibble).
  - Then the whole register shifts left by 1; counter decrements.
  - When the counter reaches 0 after the final shift (edge N+BIN_W), go to FINISH.
- FINISH, at edge N+BIN_W+1:
  - Update bcd and set overflow = ovf_pend.
  - done=1 for exactly one cycle; busy=0; go to IDLE.
  - Total latency: start-accept edge to done = BIN_W+1 cycles (15 for defaults).
- Output formatting, applied when bcd is written:
  - overflow=1: every nibble = 4'hF.
  - Otherwise, with BLANK_LZ=1: scanning from the most significant digit, each zero digit becomes 4'hF until the first non-zero digit. Digit 0 is never blanked, so value 0 shows "0".
- Handshake:
  - start while busy=1 is ignored; the current conversion is unaffected.
  - start held high continuously re-triggers a new conversion on every IDLE cycle.
  - start in the same cycle done=1 is accepted (state is IDLE), giving back-to-back conversions every BIN_W+2 cycles.
- Holding:
  - bcd and overflow change only at the FINISH edge or on reset.
  - They hold their old values during busy; the downstream decoders never see intermediate digits.
- Width rules:
  - Internal register is 4*DIGITS+BIN_W bits.
  - If 2^BIN_W-1 <= 10^DIGITS-1, overflow is constant 0.
  - No truncation of the result otherwise occurs.

Test Plan:
- Reset, then idle 5 cycles -> bcd=16'hFFFF, busy=0, done=0, overflow=0.
- bin=1234, start one cycle at edge N -> busy high edges N..N+14; done pulse after edge N+15; bcd=16'h1234, overflow=0.
- bin=0 (BLANK_LZ=1) -> bcd=16'hFFF0. bin=305 -> 16'hF305. bin=9999 -> 16'h9999. With BLANK_LZ=0, bin=7 -> 16'h0007.
- bin=10000 and bin=16383 -> overflow=1, bcd=16'hFFFF. Next conversion of bin=42 -> overflow=0, bcd=16'hFF42.
- start re-pulsed with bin=5555 mid-conversion of 1111 -> ignored, result 16'h1111. start in the done cycle with bin=88 -> accepted, second done 16 cycles after the first, bcd=16'hFF88.
- reset asserted 6 cycles into a conversion -> next edge busy=0, bcd=16'hFFFF, no done pulse. New start afterwards converts correctly.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//   Iterative shift-and-add-3 (double-dabble) binary to packed BCD converter.
//   It feeds the per-digit seven-segment decoders. Blank digits and overflow
//   digits use the code 4'hF, which the decoders show as all segments off.
//
// Ports
//   clk      : system clock; all state changes on the rising edge
//   reset    : synchronous, active-high reset
//   start    : conversion request; only looked at in IDLE
//   bin      : unsigned value; captured on the edge that accepts start
//   busy     : high while a conversion is in progress
//   done     : one-cycle pulse when bcd/overflow have just been updated
//   bcd      : packed digits; bcd[3:0] is the least significant digit
//   overflow : last converted value was above 10^DIGITS-1
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int REG_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // Largest value the digit field can display: 10^DIGITS - 1.
    function automatic logic [63:0] max_value(input int d);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < d; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_value(DIGITS);
    localparam logic [63:0] BIN_MAX = (BIN_W >= 64) ? {64{1'b1}}
                                                    : ((64'd1 << BIN_W) - 64'd1);
    // When every possible input fits in the digits, overflow is tied to 0.
    localparam bit OVF_POSSIBLE = (BIN_MAX > MAX_VAL);

    // One double-dabble step: correct each BCD nibble, then shift left.
    function automatic logic [REG_W-1:0] add3_shift(input logic [REG_W-1:0] r);
        logic [REG_W-1:0] t;
        t = r;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[BIN_W+4*d +: 4] >= 4'd5) begin
                t[BIN_W+4*d +: 4] = t[BIN_W+4*d +: 4] + 4'd3;
            end else begin
                t[BIN_W+4*d +: 4] = t[BIN_W+4*d +: 4];
            end
        end
        return {t[REG_W-2:0], 1'b0};
    endfunction

    // Display formatting applied when the result is published.
    function automatic logic [BCD_W-1:0] format_digits(input logic [BCD_W-1:0] raw,
                                                       input logic ovf);
        logic [BCD_W-1:0] f;
        logic             leading;
        if (ovf) begin
            f = {DIGITS{4'hF}};
        end else begin
            f       = raw;
            leading = 1'b1;
            if (BLANK_LZ != 0) begin
                // Digit 0 is excluded so that a value of zero still shows "0".
                for (int d = DIGITS - 1; d >= 1; d--) begin
                    if (leading && (raw[4*d +: 4] == 4'd0)) begin
                        f[4*d +: 4] = 4'hF;
                    end else begin
                        leading = 1'b0;
                    end
                end
            end else begin
                f = raw;
            end
        end
        return f;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [REG_W-1:0]   shreg_q,    shreg_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [BCD_W-1:0]   bcd_q,      bcd_d;
    logic               overflow_q, overflow_d;

    // Next-state, datapath and output update logic.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d    = {{BCD_W{1'b0}}, bin};
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = OVF_POSSIBLE && (64'(bin) > MAX_VAL);
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_SHIFT: begin
                shreg_d = add3_shift(shreg_q);
                cnt_d   = cnt_q - CNT_W'(1);
                // The step that takes the counter from 1 to 0 is the last shift.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_FINISH: begin
                bcd_d      = format_digits(shreg_q[REG_W-1 -: BCD_W], ovf_pend_q);
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= {REG_W{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= {DIGITS{4'hF}};
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//   Self-checking bench for bin_to_bcd_seq. Two instances share the inputs:
//   one with leading-zero blanking, one without. Results are compared with
//   a decimal reference model built from division and remainder.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy,     busy_nb;
    logic        done,     done_nb;
    logic [15:0] bcd,      bcd_nb;
    logic        overflow, overflow_nb;

    int n_checks;
    int n_fail;

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
    );

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy_nb), .done(done_nb), .bcd(bcd_nb), .overflow(overflow_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by arithmetic, optional leading-zero blanking.
    function automatic logic [15:0] model_bcd(input int v, input bit blank);
        logic [15:0] r;
        int          d[4];
        int          t;
        if (v > 9999) return 16'hFFFF;
        t = v;
        for (int i = 0; i < 4; i++) begin
            d[i] = t % 10;
            t    = t / 10;
            r[4*i +: 4] = 4'(d[i]);
        end
        if (blank) begin
            for (int i = 3; i >= 1; i--) begin
                if (d[i] != 0) break;
                r[4*i +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion and follows it to done. Caller sits at the done cycle.
    task automatic run_conv(input int v, input bit repulse);
        logic [15:0] prev_bcd, prev_nb;
        logic        prev_ovf;
        int          lat;
        bit          got;
        prev_bcd = bcd;
        prev_nb  = bcd_nb;
        prev_ovf = overflow;
        bin      = 14'(v);
        start    = 1'b1;
        tick();
        start = 1'b0;
        bin   = 14'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            if (repulse && lat == 5) begin
                start = 1'b1;
                bin   = 14'd5555;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (done) begin
                got = 1;
            end else begin
                check("hold_bcd", {16'd0, bcd}, {16'd0, prev_bcd});
                check("hold_bcd_nb", {16'd0, bcd_nb}, {16'd0, prev_nb});
                check("hold_ovf", {31'd0, overflow}, {31'd0, prev_ovf});
                check("busy_during", {31'd0, busy}, 32'd1);
            end
        end
        start = 1'b0;
        check("latency", lat, 32'd15);
        check("bcd", {16'd0, bcd}, {16'd0, model_bcd(v, 1'b1)});
        check("bcd_nb", {16'd0, bcd_nb}, {16'd0, model_bcd(v, 1'b0)});
        check("overflow", {31'd0, overflow}, (v > 9999) ? 32'd1 : 32'd0);
        check("overflow_nb", {31'd0, overflow_nb}, (v > 9999) ? 32'd1 : 32'd0);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic conv_and_idle(input int v);
        logic [15:0] keep;
        run_conv(v, 1'b0);
        keep = bcd;
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("bcd_stable_after", {16'd0, bcd}, {16'd0, keep});
    endtask

    initial begin
        int dcount;
        int v;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        bin      = 14'd0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_bcd", {16'd0, bcd}, 32'h0000FFFF);
        check("rst_bcd_nb", {16'd0, bcd_nb}, 32'h0000FFFF);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        // Directed values, including the display and overflow boundaries.
        conv_and_idle(1234);
        check("dir_1234", {16'd0, bcd}, 32'h00001234);
        conv_and_idle(0);
        check("dir_0", {16'd0, bcd}, 32'h0000FFF0);
        conv_and_idle(305);
        check("dir_305", {16'd0, bcd}, 32'h0000F305);
        conv_and_idle(9999);
        check("dir_9999", {16'd0, bcd}, 32'h00009999);
        conv_and_idle(7);
        check("dir_7_nb", {16'd0, bcd_nb}, 32'h00000007);
        check("dir_7", {16'd0, bcd}, 32'h0000FFF7);
        conv_and_idle(10000);
        check("dir_10000_ovf", {31'd0, overflow}, 32'd1);
        conv_and_idle(16383);
        check("dir_16383", {16'd0, bcd}, 32'h0000FFFF);
        conv_and_idle(42);
        check("dir_42", {16'd0, bcd}, 32'h0000FF42);
        check("dir_42_ovf", {31'd0, overflow}, 32'd0);

        // start during busy is ignored; start in the done cycle is accepted.
        run_conv(1111, 1'b1);
        check("repulse_1111", {16'd0, bcd}, 32'h00001111);
        run_conv(88, 1'b0);
        check("b2b_88", {16'd0, bcd}, 32'h0000FF88);
        tick();
        check("b2b_done_low", {31'd0, done}, 32'd0);

        // Reset part-way through a conversion aborts without a done pulse.
        bin   = 14'd2468;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_bcd", {16'd0, bcd}, 32'h0000FFFF);
        check("abort_ovf", {31'd0, overflow}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dcount++;
            tick();
        end
        check("abort_no_done", dcount, 32'd0);
        conv_and_idle(2468);

        // Random values, some biased to the overflow boundary.
        for (int i = 0; i < 30; i++) begin
            if (i % 4 == 0) begin
                v = int'($urandom_range(9990, 10010));
            end else begin
                v = int'($urandom_range(0, 16383));
            end
            if (i % 3 == 0) begin
                run_conv(v, 1'b0);
            end else begin
                conv_and_idle(v);
            end
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
